// File: rtl/game_sequencer_if.sv
// Signal bundle between the game sequencer and its surrounding blocks:
// frame tick, buttons and collision in; state, pulses, run-enable, speed and blink out.
interface game_sequencer_if;
  logic       i_tick_60hz;
  logic       i_button_up;
  logic       i_button_down;
  logic       i_crash;
  logic [1:0] o_state;
  logic       o_game_start_pulse;
  logic       o_game_over_pulse;
  logic       o_run_en;
  logic [2:0] o_speed;
  logic       o_blink;

  // Environment side: drives inputs, observes outputs.
  modport master (
    output i_tick_60hz, i_button_up, i_button_down, i_crash,
    input  o_state, o_game_start_pulse, o_game_over_pulse, o_run_en, o_speed, o_blink
  );

  // Sequencer side.
  modport slave (
    input  i_tick_60hz, i_button_up, i_button_down, i_crash,
    output o_state, o_game_start_pulse, o_game_over_pulse, o_run_en, o_speed, o_blink
  );
endinterface

// File: rtl/game_sequencer.sv
// Dino game flow controller: IDLE -> RUN -> CRASH -> OVER with registered
// start/game-over pulses, run-enable, saturating speed level and game-over blink.
module game_sequencer #(
  parameter int unsigned HOLD_FRAMES       = 60,
  parameter int unsigned SPEED_STEP_FRAMES = 600,
  parameter int unsigned START_SPEED       = 1,
  parameter int unsigned MAX_SPEED         = 7,
  parameter int unsigned BLINK_FRAMES      = 16
) (
  input logic               clk,
  input logic               rst_n,
  game_sequencer_if.slave   bus
);

  localparam int unsigned SpdW   = (SPEED_STEP_FRAMES > 2) ? $clog2(SPEED_STEP_FRAMES) : 1;
  localparam int unsigned HoldW  = $clog2(HOLD_FRAMES + 1);
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SpdW-1:0]   SpdLast   = SpdW'(SPEED_STEP_FRAMES - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD_FRAMES - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_FRAMES - 1);
  localparam logic [2:0]        SpeedInit = 3'(START_SPEED);
  localparam logic [2:0]        SpeedMax  = 3'(MAX_SPEED);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StCrash = 2'd2,
    StOver  = 2'd3
  } state_e;

  state_e            state_q;
  logic              up_prev_q;
  logic              start_pulse_q;
  logic              over_pulse_q;
  logic              run_en_q;
  logic [2:0]        speed_q;
  logic              blink_q;
  logic [SpdW-1:0]   spd_cnt_q;
  logic [HoldW-1:0]  hold_cnt_q;
  logic [BlinkW-1:0] blink_cnt_q;

  logic up_rise;
  assign up_rise = bus.i_button_up & ~up_prev_q;

  // Game-flow FSM with all outputs and counters registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      up_prev_q     <= 1'b1;  // a button held through reset must not start a game
      start_pulse_q <= 1'b0;
      over_pulse_q  <= 1'b0;
      run_en_q      <= 1'b0;
      speed_q       <= SpeedInit;
      blink_q       <= 1'b0;
      spd_cnt_q     <= '0;
      hold_cnt_q    <= '0;
      blink_cnt_q   <= '0;
    end else begin
      up_prev_q     <= bus.i_button_up;
      start_pulse_q <= 1'b0;
      over_pulse_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (up_rise) begin
            state_q       <= StRun;
            start_pulse_q <= 1'b1;
            run_en_q      <= 1'b1;
            speed_q       <= SpeedInit;
            spd_cnt_q     <= '0;
          end
        end
        StRun: begin
          // Crash wins over a coincident tick: speed state is left untouched.
          if (bus.i_crash) begin
            state_q      <= StCrash;
            over_pulse_q <= 1'b1;
            run_en_q     <= 1'b0;
            hold_cnt_q   <= '0;
          end else if (bus.i_tick_60hz) begin
            if (spd_cnt_q == SpdLast) begin
              spd_cnt_q <= '0;
              if (speed_q < SpeedMax) speed_q <= speed_q + 3'd1;
            end else begin
              spd_cnt_q <= spd_cnt_q + 1'b1;
            end
          end
        end
        StCrash: begin
          if (bus.i_tick_60hz) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
            if (hold_cnt_q == HoldLast) begin
              state_q     <= StOver;
              blink_q     <= 1'b0;
              blink_cnt_q <= '0;
            end
          end
        end
        StOver: begin
          if (up_rise) begin
            state_q       <= StRun;
            start_pulse_q <= 1'b1;
            run_en_q      <= 1'b1;
            speed_q       <= SpeedInit;
            spd_cnt_q     <= '0;
            blink_q       <= 1'b0;
          end else if (bus.i_button_down) begin
            state_q <= StIdle;
            blink_q <= 1'b0;
          end else if (bus.i_tick_60hz) begin
            if (blink_cnt_q == BlinkLast) begin
              blink_cnt_q <= '0;
              blink_q     <= ~blink_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Registered state drives the interface directly.
  always_comb begin
    bus.o_state            = state_q;
    bus.o_game_start_pulse = start_pulse_q;
    bus.o_game_over_pulse  = over_pulse_q;
    bus.o_run_en           = run_en_q;
    bus.o_speed            = speed_q;
    bus.o_blink            = blink_q;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for the Dino game. It owns the IDLE / RUN / CRASH / OVER sequence and turns debounced buttons, the renderer's collision flag and the 60 Hz frame tick into single-cycle start and game-over pulses. It also drives a run-enable that gates obstacle and score advance, a saturating scroll-speed level, and a blink flag for the game-over screen. It sits between the debouncers/graphics block and the player controller, obstacles, score and audio blocks.

## Interface
- HOLD_FRAMES, 60: frame ticks spent frozen in CRASH before OVER; must be ≥1.
- SPEED_STEP_FRAMES, 600: frame ticks in RUN per speed increment; must be ≥2.
- START_SPEED, 1: speed level loaded on every game start; range 0..7.
- MAX_SPEED, 7: speed saturation level; range START_SPEED..7.
- BLINK_FRAMES, 16: frame ticks per o_blink half-period in OVER; must be ≥1.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_tick_60hz  in  1  one-cycle pulse per video frame.
- i_button_up  in  1  debounced jump/start button level.
- i_button_down  in  1  debounced duck button level.
- i_crash  in  1  collision level from graphics; valid every cycle.
- o_state  out  2  current state: 0 IDLE, 1 RUN, 2 CRASH, 3 OVER.
- o_game_start_pulse  out  1  one-cycle pulse on entry to RUN.
- o_game_over_pulse  out  1  one-cycle pulse on entry to CRASH.
- o_run_en  out  1  high while in RUN.
- o_speed  out  3  current scroll-speed level.
- o_blink  out  1  game-over blink phase; 0 outside OVER.

## Operation
- All outputs are registered. Reset values: o_state=0 (IDLE), both pulse outputs 0, o_run_en=0, o_speed=START_SPEED, o_blink=0, all counters 0.
- The up-button history register resets to 1. A button held through reset therefore does not start a game.
- up_rise = i_button_up & ~up_prev. up_prev samples i_button_up every cycle, in every state.
- IDLE:
  - On up_rise, go to RUN.
  - On the same edge: o_game_start_pulse=1, o_speed=START_SPEED, speed counter cleared.
- RUN:
  - o_run_en=1.
  - On each tick, the speed counter increments. When it is at SPEED_STEP_FRAMES-1 it wraps to 0 and o_speed increments, saturating at MAX_SPEED.
  - If i_crash=1, go to CRASH with o_game_over_pulse=1.
  - Crash wins over a tick in the same cycle: neither the speed counter nor o_speed changes on that cycle.
- CRASH:
  - o_run_en=0; o_speed holds.
  - The hold counter is cleared on entry and increments on each tick.
  - On the tick where it reaches HOLD_FRAMES, go to OVER.
  - Buttons and i_crash are ignored, but up_prev still tracks.
- OVER:
  - The blink counter counts ticks. o_blink toggles every BLINK_FRAMES ticks, starting at 0 on entry.
  - On up_rise, go to RUN (restart): start pulse, speed reload and counter clear exactly as from IDLE; o_blink cleared.
  - Else, if i_button_down=1, go to IDLE with o_blink cleared.
  - up_rise has priority over i_button_down.
- i_crash outside RUN has no effect.
- Counter widths are sized to hold their terminal values. No arithmetic overflow is possible; o_speed never exceeds MAX_SPEED.

## Timing
- Transition latency is one clock: an input condition sampled at edge k gives the new o_state and the pulse in the cycle after edge k.
- Pulses are high for exactly one cycle, coincident with the first cycle of the new state.
- o_run_en changes on the same edge as o_state.
- A tick and a state transition on the same edge: the tick is consumed by the source state only; the new state's counters start from 0.
- Async reset mid-operation forces reset values immediately, independent of clk. The first transition after deassertion requires a fresh button rise.

## Test plan
- Start from reset: hold i_button_up=1 through reset release -> stays IDLE. Drop it, then raise it at edge k -> o_state=1 and o_game_start_pulse=1 only for the cycle after edge k; o_run_en=1; o_speed=START_SPEED.
- Speed ramp (SPEED_STEP_FRAMES=4, START_SPEED=1, MAX_SPEED=3): 12 ticks in RUN -> o_speed reads 2 after the 4th tick and 3 after the 8th; stays 3 after the 12th.
- Crash priority (HOLD_FRAMES=3): assert i_crash in the same cycle as a tick -> o_state=2, one-cycle o_game_over_pulse, o_speed unchanged, o_run_en=0. Exactly 3 ticks later -> o_state=3.
- Restart needs a fresh press: hold i_button_up from RUN through CRASH into OVER -> stays OVER. Release and re-press -> RUN, start pulse, o_speed=START_SPEED, o_blink=0.
- OVER blink and exit (BLINK_FRAMES=2): o_blink pattern 0,0,1,1,0 across ticks 0-4. Assert i_button_down and i_button_up rise together -> RUN. Assert i_button_down alone -> IDLE, o_blink=0.
- Reset mid-RUN at speed 2: pull rst_n low between clock edges -> all outputs at reset values immediately. After release, no state change until a new button rise.
